// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with per-cycle step, wrap-or-saturate
// boundary handling, one-shot halt and terminal-count/boundary status.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             oneshot,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             boundary,
  output logic             halted
);

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_X = MAX_X + {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_X = {(WIDTH+1){1'b0}};

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] next_count;
  logic             next_boundary;

  logic [WIDTH:0] count_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] load_x;
  logic [WIDTH:0] eff_step;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] up_res;
  logic [WIDTH:0] dn_res;
  logic           up_cross;
  logic           up_reach;
  logic           dn_cross;
  logic           dn_reach;

  // One extra bit of headroom keeps overflow/underflow visible for crossing detection.
  assign count_x  = {1'b0, data_out};
  assign step_x   = {1'b0, step};
  assign load_x   = {1'b0, data_in};
  assign eff_step = (step_x > MAX_X) ? MAX_X : step_x;
  assign sum      = count_x + eff_step;

  assign up_cross = (sum > MAX_X);
  assign up_reach = (sum >= MAX_X);
  assign dn_cross = (eff_step > count_x);
  assign dn_reach = (eff_step >= count_x);

  assign up_res = up_cross ? (SATURATE ? MAX_X : (sum - MOD_X)) : sum;
  assign dn_res = dn_cross ? (SATURATE ? ZERO_X : (count_x + MOD_X - eff_step))
                           : (count_x - eff_step);

  assign tc = up_down ? (data_out == MAX_W) : (data_out == {WIDTH{1'b0}});

  // Next-state, next-count and boundary pulse: load > enabled update > hold.
  always_comb begin
    next_state    = state;
    next_count    = data_out;
    next_boundary = 1'b0;
    if (load) begin
      next_state = RUN;
      next_count = (load_x > MAX_X) ? MAX_W : data_in;
    end else if (enable && (state == RUN)) begin
      if (up_down) begin
        next_boundary = up_cross;
        if (oneshot && up_reach) begin
          next_count = MAX_W;
          next_state = HALT;
        end else begin
          next_count = WIDTH'(up_res);
        end
      end else begin
        next_boundary = dn_cross;
        if (oneshot && dn_reach) begin
          next_count = {WIDTH{1'b0}};
          next_state = HALT;
        end else begin
          next_count = WIDTH'(dn_res);
        end
      end
    end else begin
      next_count = data_out;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      data_out <= {WIDTH{1'b0}};
      boundary <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= next_state;
      data_out <= next_count;
      boundary <= next_boundary;
      halted   <= (next_state == HALT);
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench: a wrapping and a saturating instance (MAX_VAL=9) share
// stimulus; an integer reference model queues expected outputs per edge.
module tb_mod_counter;

  localparam int W  = 8;
  localparam int MX = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic         up_down = 1'b1;
  logic         oneshot = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] step = '0;

  logic [W-1:0] dout_w, dout_s;
  logic         tc_w, tc_s, bnd_w, bnd_s, hlt_w, hlt_s;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(W), .MAX_VAL(MX), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
    .up_down(up_down), .step(step), .oneshot(oneshot),
    .data_out(dout_w), .tc(tc_w), .boundary(bnd_w), .halted(hlt_w)
  );

  mod_counter #(.WIDTH(W), .MAX_VAL(MX), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
    .up_down(up_down), .step(step), .oneshot(oneshot),
    .data_out(dout_s), .tc(tc_s), .boundary(bnd_s), .halted(hlt_s)
  );

  typedef struct {
    int cnt;
    int bnd;
    int halt;
    int tc;
  } exp_t;

  exp_t q_wrap[$];
  exp_t q_sat[$];
  int   m_cnt[2];
  int   m_halt[2];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: spec rules in plain signed integer arithmetic.
  task automatic model_step(input int idx);
    bit   sat;
    bit   crossed;
    bit   reach;
    int   s;
    int   t;
    exp_t e;
    sat   = (idx == 1);
    e.bnd = 0;
    if (reset) begin
      m_cnt[idx]  = 0;
      m_halt[idx] = 0;
    end else if (load) begin
      m_cnt[idx]  = (int'(data_in) > MX) ? MX : int'(data_in);
      m_halt[idx] = 0;
    end else if (enable && m_halt[idx] == 0) begin
      s       = (int'(step) > MX) ? MX : int'(step);
      t       = up_down ? m_cnt[idx] + s : m_cnt[idx] - s;
      crossed = (t > MX) || (t < 0);
      reach   = up_down ? (t >= MX) : (t <= 0);
      if (oneshot && reach) begin
        m_cnt[idx]  = up_down ? MX : 0;
        m_halt[idx] = 1;
      end else if (!crossed) begin
        m_cnt[idx] = t;
      end else if (sat) begin
        m_cnt[idx] = up_down ? MX : 0;
      end else begin
        m_cnt[idx] = up_down ? t - (MX + 1) : t + (MX + 1);
      end
      e.bnd = crossed ? 1 : 0;
    end
    e.cnt  = m_cnt[idx];
    e.halt = m_halt[idx];
    e.tc   = up_down ? (m_cnt[idx] == MX) : (m_cnt[idx] == 0);
    if (sat) q_sat.push_back(e);
    else     q_wrap.push_back(e);
  endtask

  task automatic drive(input bit rs, input bit ld, input int din, input bit en,
                       input bit ud, input int st, input bit os);
    @(negedge clk);
    reset   = rs;
    load    = ld;
    data_in = din[W-1:0];
    enable  = en;
    up_down = ud;
    step    = st[W-1:0];
    oneshot = os;
    model_step(0);
    model_step(1);
  endtask

  // Monitor: compare each instance after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_wrap.size() > 0) begin
        e = q_wrap.pop_front();
        check("wrap_count", int'(dout_w), e.cnt);
        check("wrap_boundary", int'(bnd_w), e.bnd);
        check("wrap_halted", int'(hlt_w), e.halt);
        check("wrap_tc", int'(tc_w), e.tc);
      end
      if (q_sat.size() > 0) begin
        e = q_sat.pop_front();
        check("sat_count", int'(dout_s), e.cnt);
        check("sat_boundary", int'(bnd_s), e.bnd);
        check("sat_halted", int'(hlt_s), e.halt);
        check("sat_tc", int'(tc_s), e.tc);
      end
    end
  end

  initial begin
    int r;
    // Reset and idle
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    // Wrap up through MAX_VAL
    drive(0, 1, 8, 0, 1, 1, 0);
    repeat (3) drive(0, 0, 0, 1, 1, 1, 0);
    // Down across zero, then zero step
    drive(0, 1, 1, 0, 0, 3, 0);
    drive(0, 0, 0, 1, 0, 3, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    // Saturating clamp twice, then oversize step down
    drive(0, 1, 7, 0, 1, 4, 0);
    drive(0, 0, 0, 1, 1, 4, 0);
    drive(0, 0, 0, 1, 1, 4, 0);
    drive(0, 0, 0, 1, 0, 20, 0);
    // One-shot halt, held edges with oneshot dropped, load releases
    drive(0, 1, 7, 0, 1, 2, 0);
    drive(0, 0, 0, 1, 1, 2, 1);
    drive(0, 0, 0, 1, 1, 2, 1);
    drive(0, 0, 0, 1, 0, 5, 0);
    drive(0, 1, 3, 0, 1, 1, 0);
    // Load clamp and load beating enable
    drive(0, 1, 200, 0, 1, 1, 0);
    drive(0, 1, 5, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    // Asynchronous reset mid-cycle with boundary high on the wrap instance
    drive(0, 1, 9, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 7, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_wrap_count", int'(dout_w), 0);
    check("async_wrap_boundary", int'(bnd_w), 0);
    check("async_wrap_halted", int'(hlt_w), 0);
    check("async_sat_count", int'(dout_s), 0);
    check("async_sat_boundary", int'(bnd_s), 0);
    check("async_sat_halted", int'(hlt_s), 0);
    drive(1, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      drive(0, ($urandom_range(0, 9) == 0), $urandom_range(0, 255),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            (r == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12),
            ($urandom_range(0, 7) == 0));
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", q_wrap.size() + q_sat.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, the next generation of the team's basic loadable up/down counter. Adds configurable width and modulus, a per-cycle step size, a wrap-or-saturate mode, a one-shot halt mode, and boundary/terminal-count status outputs. It sits in the same place in the design as the basic counter, driven by the same interface-style stimulus: load/enable/direction in, count out.

## Interface
- WIDTH, 8, counter and data width in bits.
- MAX_VAL, 2**WIDTH-1, top of count range; the count is always in 0..MAX_VAL. Legal range is 1..2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 = wrap modulo MAX_VAL+1, 1 = clamp at 0/MAX_VAL.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count-update enable.
- load  in  1  synchronous load of data_in.
- data_in  in  WIDTH  load value.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  WIDTH  increment/decrement magnitude.
- oneshot  in  1  1 = halt on reaching or crossing a boundary.
- data_out  out  WIDTH  current count (registered).
- tc  out  1  terminal count, combinational from registers: data_out==MAX_VAL when up_down=1, data_out==0 when up_down=0.
- boundary  out  1  registered one-cycle pulse, high after an update that crossed a boundary.
- halted  out  1  one-shot halt state (registered).

## Operation
- Reset values: data_out=0, boundary=0, halted=0, FSM=RUN. Reset takes effect immediately, independent of clk.
- FSM has two states.
  - RUN: normal counting.
  - HALT: entered only when oneshot=1. Enable is ignored and data_out holds. Load returns to RUN. oneshot=0 does not leave HALT; only load or reset does.
- Priority per edge: reset > load > enable > hold.
- Load:
  - data_out <= min(data_in, MAX_VAL).
  - halted <= 0, boundary <= 0.
  - Load is honoured regardless of enable.
- Effective step: s = min(step, MAX_VAL). With s=0 the count holds and boundary stays 0.
- Arithmetic uses WIDTH+1 bits internally; no silent truncation.
- Up: sum = data_out + s.
  - If sum <= MAX_VAL: data_out <= sum.
  - Otherwise a crossing occurs: SATURATE=0 gives sum-(MAX_VAL+1); SATURATE=1 gives MAX_VAL.
- Down:
  - If s <= data_out: data_out <= data_out - s.
  - Otherwise a crossing occurs: SATURATE=0 gives data_out+(MAX_VAL+1)-s; SATURATE=1 gives 0.
- boundary: high for exactly one cycle after any enabled update that crossed, including repeated clamp attempts while saturated. Otherwise 0.
- One-shot (oneshot=1, RUN, enabled update):
  - If the result reaches or would cross the boundary in the current direction, data_out <= that boundary (MAX_VAL up, 0 down), regardless of SATURATE.
  - halted <= 1, FSM -> HALT.
  - boundary pulses only if a true crossing occurred.
- up_down, step and oneshot are sampled per edge and may change every cycle.

## Timing
- Latency: one clock from sampled enable/load to the new data_out; boundary and halted update on the same edge.
- tc follows data_out and up_down combinationally, with no extra cycle.
- Reset asserted mid-operation clears all outputs asynchronously. On deassertion, counting resumes on the first edge with enable=1.
- load and enable high on the same edge: load wins and no count occurs.
- MAX_VAL < 2**WIDTH-1: values above MAX_VAL never appear on data_out.

## Test plan
- Wrap up, WIDTH=8, MAX_VAL=9, SATURATE=0: load 8, enable, up, step 1 -> 9 (tc=1), then 0 with boundary=1 for one cycle, then 1 with boundary=0.
- Wrap down, same instance: load 1, down, step 3 -> 8 with boundary pulse. Then step 0 -> holds 8, boundary=0.
- Saturate, MAX_VAL=9, SATURATE=1: load 7, up, step 4 -> 9 with boundary=1. Next edge -> 9 with boundary=1 again. Down, step 20 -> step clamps to 9, count goes to 0.
- One-shot: load 7, oneshot=1, up, step 2 -> 9, halted=1, boundary=0. Further enabled edges hold 9. Load 3 -> data_out=3, halted=0.
- Load rules: load 200 with MAX_VAL=9 -> 9. Load 5 with enable=1, up, step 1 -> 5, not 6.
- Async reset: assert reset mid-cycle at count 6 with boundary high -> data_out=0, boundary=0, halted=0 before the next edge. Release -> counting resumes from 0.
